// File: rtl/uart_result_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a small FIFO,
// serialized LSB-first on TXD with back-to-back frames while bytes remain queued.
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    DATA_IN,
  input  logic                          DATA_VALID,
  output logic                          DATA_READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_end;

  assign DATA_READY = (count_q < DEPTH_C);
  assign push       = DATA_VALID & DATA_READY;
  assign bit_end    = (baud_q == BAUD_LAST);
  assign TXD        = txd_q;
  assign BUSY       = (state_q != S_IDLE) | (count_q != '0);
  assign FIFO_COUNT = count_q;

  // txd_d always carries the line level of the state being entered, so TXD is a clean flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Scoreboard bench for uart_result_tx: accepted bytes are queued, and a TXD monitor
// checks every cycle of each frame against the queued byte.
module tb_uart_result_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       CLK;
  logic       RESET;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       TXD;
  logic       BUSY;
  logic [2:0] FIFO_COUNT;

  uart_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .FIFO_COUNT (FIFO_COUNT)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int frames_done = 0;
  logic abort;
  logic [7:0] exp_q [$];
  int frame_starts [$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: a low TXD while idle starts a frame; all 10*CPB cycles are compared.
  initial begin
    logic [7:0] b;
    logic [9:0] fb;
    logic       have, ok, aborted;
    int         st;
    forever begin
      @(posedge CLK); #1;
      if (!abort && TXD === 1'b0) begin
        st      = cyc;
        have    = (exp_q.size() != 0);
        b       = have ? exp_q.pop_front() : 8'h00;
        fb      = {1'b1, b, 1'b0};
        ok      = 1'b1;
        aborted = 1'b0;
        for (int c = 0; c < 10*CPB; c++) begin
          if (c > 0) begin @(posedge CLK); #1; end
          if (abort) begin aborted = 1'b1; break; end
          if (TXD !== fb[c/CPB]) ok = 1'b0;
        end
        if (!aborted) begin
          checks++;
          if (!have)
            $display("FAIL frame: got unexpected frame at cycle %0d expected no frame", st);
          else if (ok) passes++;
          else $display("FAIL frame: byte %0h wrong bit pattern on TXD starting cycle %0d", b, st);
          frame_starts.push_back(st);
          frames_done++;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic acc, input string name);
    DATA_IN    = b;
    DATA_VALID = 1'b1;
    chk(name, DATA_READY, acc);
    if (acc) exp_q.push_back(b);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    DATA_IN    = 8'($urandom);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 2000) begin @(negedge CLK); n++; end
    chk("idle_reached", BUSY, 1'b0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p, n0, bad;
    RESET = 1'b1; abort = 1'b1; DATA_VALID = 1'b0; DATA_IN = 8'h00;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_txd", TXD, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_count", FIFO_COUNT, 3'd0);
    chk("rst_ready", DATA_READY, 1'b1);
    abort = 1'b0;
    bad = 0;
    repeat (20) begin @(negedge CLK); if (TXD !== 1'b1) bad++; end
    chk("t1_idle_txd", bad, 0);

    // single byte: latency and BUSY fall
    n0 = frames_done; p = cyc;
    push_byte(8'hA5, 1'b1, "t2_ready");
    wait_cyc(p + 41);
    chk("t2_busy_hi", BUSY, 1'b1);
    wait_cyc(p + 42);
    chk("t2_busy_lo", BUSY, 1'b0);
    wait_idle();
    chk("t2_frames", frames_done - n0, 1);
    chk("t2_start", frame_starts[n0], p + 2);

    // back-to-back burst
    n0 = frames_done; p = cyc;
    push_byte(8'h01, 1'b1, "t3_ready0");
    push_byte(8'h80, 1'b1, "t3_ready1");
    push_byte(8'hFF, 1'b1, "t3_ready2");
    wait_idle();
    chk("t3_frames", frames_done - n0, 3);
    chk("t3_start0", frame_starts[n0], p + 2);
    chk("t3_start1", frame_starts[n0+1], p + 42);
    chk("t3_start2", frame_starts[n0+2], p + 82);

    // overflow while a frame is in flight
    n0 = frames_done; p = cyc;
    push_byte(8'h5A, 1'b1, "t4_ready_first");
    wait_cyc(p + 10);
    push_byte(8'hC3, 1'b1, "t4_ready0");
    push_byte(8'h3C, 1'b1, "t4_ready1");
    push_byte(8'h96, 1'b1, "t4_ready2");
    push_byte(8'h69, 1'b1, "t4_ready3");
    push_byte(8'hDE, 1'b0, "t4_full0");
    push_byte(8'hAD, 1'b0, "t4_full1");
    chk("t4_count", FIFO_COUNT, 3'd4);
    wait_idle();
    chk("t4_frames", frames_done - n0, 5);

    // push and pop on the same edge at the end of STOP
    n0 = frames_done; p = cyc;
    push_byte(8'h12, 1'b1, "t5_ready0");
    push_byte(8'h34, 1'b1, "t5_ready1");
    push_byte(8'h56, 1'b1, "t5_ready2");
    wait_cyc(p + 41);
    chk("t5_count_before", FIFO_COUNT, 3'd2);
    push_byte(8'h78, 1'b1, "t5_ready3");
    chk("t5_count_after", FIFO_COUNT, 3'd2);
    wait_idle();
    chk("t5_frames", frames_done - n0, 4);
    chk("t5_start1", frame_starts[n0+1], p + 42);

    // reset during DATA bit 3 of 0x00 with two bytes queued
    n0 = frames_done; p = cyc;
    push_byte(8'h00, 1'b1, "t6_ready0");
    push_byte(8'h11, 1'b1, "t6_ready1");
    push_byte(8'h22, 1'b1, "t6_ready2");
    wait_cyc(p + 19);
    abort = 1'b1;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("t6_txd", TXD, 1'b1);
    chk("t6_count", FIFO_COUNT, 3'd0);
    chk("t6_busy", BUSY, 1'b0);
    chk("t6_ready", DATA_READY, 1'b1);
    exp_q.delete();
    abort = 1'b0;
    repeat (60) @(negedge CLK);
    chk("t6_no_frames", frames_done - n0, 0);
    push_byte(8'h3C, 1'b1, "t6_ready_new");
    wait_idle();
    chk("t6_new_frame", frames_done - n0, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
